// File: rtl/gctr_keystream_xor_pkg.sv
// Shared GCM definitions for the GCTR keystream stage: block width, J0 suffix,
// FSM state encodings and the last-block byte mask helper.
package gctr_keystream_xor_pkg;

  localparam int unsigned GCM_BLK_W = 128;
  localparam logic [31:0] J0_SUFFIX = 32'h0000_0001;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_J0_REQ   = 3'd1;
  localparam logic [2:0] S_J0_WAIT  = 3'd2;
  localparam logic [2:0] S_CTR_REQ  = 3'd3;
  localparam logic [2:0] S_CTR_WAIT = 3'd4;
  localparam logic [2:0] S_KS_REQ   = 3'd5;
  localparam logic [2:0] S_KS_WAIT  = 3'd6;
  localparam logic [2:0] S_XFER     = 3'd7;

  // MSB-first mask keeping bytes 0..n-1 (byte 0 = bits [127:120]); n==0 keeps all 16.
  function automatic logic [127:0] byte_mask(input logic [4:0] n);
    logic [127:0] m;
    int unsigned  lim;
    m   = '0;
    lim = (n == 5'd0) ? 32'd16 : {27'd0, n};
    for (int unsigned i = 0; i < 16; i++) begin
      m = {m[119:0], (i < lim) ? 8'hFF : 8'h00};
    end
    return m;
  endfunction

endpackage

// File: rtl/gctr_keystream_xor.sv
// GCTR consumer: loads the IV, encrypts J0 for the tag mask, then per block
// fetches a counter, encrypts it and XORs the keystream with the data stream.
module gctr_keystream_xor
  import gctr_keystream_xor_pkg::*;
#(
  parameter int unsigned BLK_W     = GCM_BLK_W,
  parameter bit          ZERO_TAIL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [95:0]      iv96,
  output logic             ctr_load,
  output logic [95:0]      ctr_iv,
  output logic             ctr_next,
  input  logic [BLK_W-1:0] ctr_block,
  input  logic             ctr_valid,
  input  logic             aes_ready,
  output logic             aes_start,
  output logic [BLK_W-1:0] aes_block,
  input  logic [BLK_W-1:0] aes_result,
  input  logic             aes_res_valid,
  output logic [BLK_W-1:0] tag_mask,
  output logic             tag_mask_valid,
  input  logic [BLK_W-1:0] din,
  input  logic             din_valid,
  input  logic             din_last,
  input  logic [4:0]       din_bytes,
  output logic             din_ready,
  output logic [BLK_W-1:0] dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic [4:0]       dout_bytes,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done
);

  logic [2:0]       r_state;
  logic [95:0]      r_ctr_iv;
  logic             r_ctr_load;
  logic [BLK_W-1:0] r_aes_block;
  logic [BLK_W-1:0] r_ks;
  logic [BLK_W-1:0] r_tag_mask;
  logic             r_tag_mask_valid;
  logic [BLK_W-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_dout_last;
  logic [4:0]       r_dout_bytes;
  logic             r_done;

  logic             w_go;
  logic             w_din_fire;
  logic             w_dout_fire;
  logic [BLK_W-1:0] w_xor;

  // Request pulses are decoded from state so no request escapes during abort or reset.
  assign w_go        = rst_n & ~abort;
  assign ctr_next    = w_go & (r_state == S_CTR_REQ);
  assign aes_start   = w_go & aes_ready & ((r_state == S_J0_REQ) | (r_state == S_KS_REQ));
  assign din_ready   = w_go & (r_state == S_XFER) & (~r_dout_valid | dout_ready);
  assign w_din_fire  = din_valid & din_ready;
  assign w_dout_fire = r_dout_valid & dout_ready;

  always_comb begin
    w_xor = din ^ r_ks;
    if (ZERO_TAIL && din_last) w_xor = w_xor & byte_mask(din_bytes);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_ctr_iv         <= '0;
      r_ctr_load       <= 1'b0;
      r_aes_block      <= '0;
      r_ks             <= '0;
      r_tag_mask       <= '0;
      r_tag_mask_valid <= 1'b0;
      r_dout           <= '0;
      r_dout_valid     <= 1'b0;
      r_dout_last      <= 1'b0;
      r_dout_bytes     <= '0;
      r_done           <= 1'b0;
    end else begin
      r_ctr_load <= 1'b0;
      r_done     <= 1'b0;
      if (w_dout_fire) r_dout_valid <= 1'b0;
      if (abort) begin
        r_state          <= S_IDLE;
        r_dout_valid     <= 1'b0;
        r_tag_mask_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_ctr_iv         <= iv96;
            r_ctr_load       <= 1'b1;
            r_tag_mask_valid <= 1'b0;
            // J0 is staged here so J0_REQ presents {ctr_iv, suffix} straight from the register.
            r_aes_block      <= {iv96, J0_SUFFIX};
            r_state          <= S_J0_REQ;
          end
          S_J0_REQ:  if (aes_ready) r_state <= S_J0_WAIT;
          S_J0_WAIT: if (aes_res_valid) begin
            r_tag_mask       <= aes_result;
            r_tag_mask_valid <= 1'b1;
            r_state          <= S_CTR_REQ;
          end
          S_CTR_REQ:  r_state <= S_CTR_WAIT;
          S_CTR_WAIT: if (ctr_valid) begin
            r_aes_block <= ctr_block;
            r_state     <= S_KS_REQ;
          end
          S_KS_REQ:  if (aes_ready) r_state <= S_KS_WAIT;
          S_KS_WAIT: if (aes_res_valid) begin
            r_ks    <= aes_result;
            r_state <= S_XFER;
          end
          S_XFER: if (w_din_fire) begin
            r_dout       <= w_xor;
            r_dout_valid <= 1'b1;
            r_dout_last  <= din_last;
            r_dout_bytes <= din_last ? din_bytes : 5'd16;
            if (din_last) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_CTR_REQ;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ctr_load       = r_ctr_load;
  assign ctr_iv         = r_ctr_iv;
  assign aes_block      = r_aes_block;
  assign tag_mask       = r_tag_mask;
  assign tag_mask_valid = r_tag_mask_valid;
  assign dout           = r_dout;
  assign dout_valid     = r_dout_valid;
  assign dout_last      = r_dout_last;
  assign dout_bytes     = r_dout_bytes;
  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;

endmodule
